ex_alu_unit: RTL and testbench

- Execute-stage ALU, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU_controls code plus two operands from the ID/EX path.
- Produces a registered result, a zero flag and a result-valid strobe.
- Adds a multi-cycle unsigned shift-add multiply. A busy output stalls the pipeline while the multiply runs.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_mult.sv | 62 ++++++
 rtl/ex_alu_unit.sv | 145 ++++++++++++++
 tb/tb_ex_alu_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the execute-stage ALU slice:
//     - ALU_controls operation codes understood by ex_alu_unit
//     - FSM state encoding of ex_alu_unit (IDLE -> MUL -> DONE -> IDLE)
//     - cnt_width(): width of the multiply iteration counter
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'd0;
   localparam logic [3:0] ALU_OR    = 4'd1;
   localparam logic [3:0] ALU_ADD   = 4'd2;
   localparam logic [3:0] ALU_SUB   = 4'd6;
   localparam logic [3:0] ALU_SLT   = 4'd7;
   localparam logic [3:0] ALU_MULTU = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // The counter must hold the value WIDTH itself, hence one extra bit.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/alu_seq_mult.sv
// ---------------------------------------------------------------------------
// alu_seq_mult
//   Iterative unsigned shift-add multiplier, one partial product per cycle.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     start         load a/b, clear the accumulator, start WIDTH iterations
//     a, b          multiplicand / multiplier (sampled only on start)
//     done          high in the cycle that performs the final iteration
//     product       2*WIDTH accumulator; holds the full product once the
//                   final iteration has been clocked in
// ---------------------------------------------------------------------------
module alu_seq_mult #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   import alu_pkg::*;

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     upper_sum;

   assign addend    = multiplier[0] ? multiplicand : '0;
   // Carry out of the upper half is kept so the right shift brings it in.
   assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         multiplicand <= '0;
         multiplier   <= '0;
         acc          <= '0;
         count        <= '0;
      end else if (start) begin
         multiplicand <= a;
         multiplier   <= b;
         acc          <= '0;
         count        <= CNT_INIT;
      end else if (count != '0) begin
         acc        <= {upper_sum, acc[WIDTH-1:1]};
         multiplier <= multiplier >> 1;
         count      <= count - CNT_ONE;
      end
   end

   // No early exit: a zero multiplier still runs all WIDTH iterations.
   assign done    = (count == CNT_ONE);
   assign product = acc;

endmodule

// File: rtl/ex_alu_unit.sv
// ---------------------------------------------------------------------------
// ex_alu_unit
//   Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus a multi-cycle
//   unsigned multiply (MULTU) that stalls the pipeline through busy.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     valid_in          operands and ALU_controls valid this cycle
//     ALU_controls      0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 8 MULTU
//     operand_a/b       source operands
//     result            registered result (low product half for MULTU)
//     result_hi         high product half, written only by MULTU
//     zero              registered (result == 0)
//     result_valid      one-cycle strobe when the outputs are new
//     busy              stall request: accept cycle of MULTU and all MUL cycles
//     overflow          (only with ALU_OVERFLOW_EN) signed ADD/SUB overflow
//   Handshake: an op is taken in any IDLE cycle with valid_in=1. While busy,
//   upstream holds its inputs and valid_in is ignored; the DONE cycle also
//   ignores valid_in, and the next op is taken in the cycle after DONE.
//   Optional feature macro: ALU_OVERFLOW_EN.
// ---------------------------------------------------------------------------
module ex_alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [3:0]       ALU_controls,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             result_valid,
   output logic             busy
`ifdef ALU_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);
   import alu_pkg::*;

   alu_state_e         state;
   alu_state_e         state_next;
   logic               accept;
   logic               start_mul;
   logic               mul_done;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   op_res;

   assign accept    = (state == IDLE) && valid_in;
   assign start_mul = accept && (ALU_controls == ALU_MULTU);

   assign sum  = operand_a + operand_b;
   assign diff = operand_a - operand_b;

   // Single-cycle operation mux; undefined codes yield 0.
   always_comb begin
      op_res = '0;
      case (ALU_controls)
         ALU_AND: op_res = operand_a & operand_b;
         ALU_OR:  op_res = operand_a | operand_b;
         ALU_ADD: op_res = sum;
         ALU_SUB: op_res = diff;
         ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         default: op_res = '0;
      endcase
   end

`ifdef ALU_OVERFLOW_EN
   logic op_ovf;

   always_comb begin
      op_ovf = 1'b0;
      case (ALU_controls)
         ALU_ADD: op_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                           (sum[WIDTH-1] != operand_a[WIDTH-1]);
         ALU_SUB: op_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                           (diff[WIDTH-1] != operand_a[WIDTH-1]);
         default: op_ovf = 1'b0;
      endcase
   end
`endif

   alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
      .clk     (clk),
      .rst     (rst),
      .start   (start_mul),
      .a       (operand_a),
      .b       (operand_b),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_mul) state_next = MUL;
         MUL:     if (mul_done)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Stall starts combinationally in the accept cycle so upstream holds the
   // operands; it is forced low while reset is asserted.
   assign busy = !rst && ((state == MUL) || start_mul);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result       <= '0;
         result_hi    <= '0;
         zero         <= 1'b0;
         result_valid <= 1'b0;
`ifdef ALU_OVERFLOW_EN
         overflow     <= 1'b0;
`endif
      end else begin
         result_valid <= 1'b0;
         if (state == DONE) begin
            result       <= product[WIDTH-1:0];
            result_hi    <= product[2*WIDTH-1:WIDTH];
            zero         <= (product[WIDTH-1:0] == '0);
            result_valid <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            overflow     <= 1'b0;
`endif
         end else if (accept && !start_mul) begin
            result       <= op_res;
            zero         <= (op_res == '0);
            result_valid <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            overflow     <= op_ovf;
`endif
         end
      end
   end

endmodule

// File: tb/tb_ex_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_alu_unit
//   Self-checking bench for ex_alu_unit (WIDTH=32). Directed vector table,
//   hand-written multiply / stall / abort sequences, then randomized ops
//   checked against an arithmetic reference model. Every strobe is matched
//   against an expected queue. Honours ALU_OVERFLOW_EN.
// ---------------------------------------------------------------------------
module tb_ex_alu_unit;
   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         valid_in;
   logic [3:0]   alu_controls;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         zero;
   logic         result_valid;
   logic         busy;
`ifdef ALU_OVERFLOW_EN
   logic         overflow;
`endif

   ex_alu_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .ALU_controls (alu_controls),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .result       (result),
      .result_hi    (result_hi),
      .zero         (zero),
      .result_valid (result_valid),
      .busy         (busy)
`ifdef ALU_OVERFLOW_EN
      ,
      .overflow     (overflow)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_hi_q[$];
   logic         exp_ovf_q[$];
   logic [W-1:0] model_hi = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] res, input logic [W-1:0] hi, input logic ovf);
      exp_q.push_back(res);
      exp_hi_q.push_back(hi);
      exp_ovf_q.push_back(ovf);
   endtask

   // Every strobe must correspond to an expected completion, in order.
   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got strobe with result %0h expected none", result);
         end else begin
            check("sb_result", result, exp_q.pop_front());
            check("sb_result_hi", result_hi, exp_hi_q.pop_front());
`ifdef ALU_OVERFLOW_EN
            check("sb_overflow", overflow, exp_ovf_q.pop_front());
`else
            void'(exp_ovf_q.pop_front());
`endif
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_res(input logic [3:0] code,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      case (code)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return (sa < sb) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   function automatic logic model_ovf(input logic [3:0] code,
                                      input logic [W-1:0] a,
                                      input logic [W-1:0] b);
      longint sa   = longint'($signed(a));
      longint sb   = longint'($signed(b));
      longint smax = (longint'(1) << (W-1)) - 1;
      longint smin = -(longint'(1) << (W-1));
      longint s;
      if (code == 4'd2)      s = sa + sb;
      else if (code == 4'd6) s = sa - sb;
      else                   return 1'b0;
      return (s > smax) || (s < smin);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_single(input string name, input logic [3:0] code,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_res, input logic exp_zero,
                             input logic exp_ovf);
      alu_controls = code;
      operand_a    = a;
      operand_b    = b;
      valid_in     = 1'b1;
      #1;
      check({name, "_busy"}, busy, 0);
      push_exp(exp_res, model_hi, exp_ovf);
      tick();
      valid_in = 1'b0;
      check({name, "_strobe"}, result_valid, 1);
      check({name, "_result"}, result, exp_res);
      check({name, "_zero"}, zero, exp_zero);
      tick();
      check({name, "_strobe_width"}, result_valid, 0);
   endtask

   // Returns with the strobe cycle current, so an op may be driven at once.
   task automatic run_mul(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit inject);
      longint unsigned p;
      int busy_cycles;
      int edges;
      bit got;
      p = longint'(a) * longint'(b);
      alu_controls = 4'd8;
      operand_a    = a;
      operand_b    = b;
      valid_in     = 1'b1;
      #1;
      check({name, "_busy_at_accept"}, busy, 1);
      push_exp(p[W-1:0], p[2*W-1:W], 1'b0);
      model_hi = p[2*W-1:W];
      tick();
      if (inject) begin
         // A competing ADD held under the stall must be ignored.
         alu_controls = 4'd2;
         operand_a    = 1;
         operand_b    = 1;
         valid_in     = 1'b1;
      end else begin
         valid_in = 1'b0;
      end
      busy_cycles = 0;
      edges = 0;
      got = 0;
      while (!got && edges < 60) begin
         if (result_valid === 1'b1) begin
            got = 1;
         end else begin
            if (busy === 1'b1) busy_cycles++;
            else valid_in = 1'b0;
            tick();
            edges++;
         end
      end
      valid_in = 1'b0;
      check({name, "_completed"}, got, 1);
      check({name, "_latency"}, edges, W + 1);
      check({name, "_busy_cycles"}, busy_cycles, W);
      check({name, "_lo"}, result, p[W-1:0]);
      check({name, "_hi"}, result_hi, p[2*W-1:W]);
      check({name, "_zero"}, zero, p[W-1:0] == 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0]   code;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         zero;
      logic         ovf;
   } vec_t;

   vec_t vecs[10];
   int   undef_codes[10] = '{3, 4, 5, 9, 10, 11, 12, 13, 14, 15};
   int   ops[6] = '{0, 1, 2, 6, 7, 8};

   initial begin
      vecs[0] = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
      vecs[1] = '{4'd6,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
      vecs[2] = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
      vecs[3] = '{4'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
      vecs[4] = '{4'd1,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0};
      vecs[5] = '{4'd4,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0};
      vecs[6] = '{4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
      vecs[7] = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      vecs[8] = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
      vecs[9] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};

      // Reset state
      rst = 1'b1;
      valid_in = 1'b0;
      alu_controls = '0;
      operand_a = '0;
      operand_b = '0;
      #2;
      check("rst_result", result, 0);
      check("rst_result_hi", result_hi, 0);
      check("rst_zero", zero, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_busy", busy, 0);
`ifdef ALU_OVERFLOW_EN
      check("rst_overflow", overflow, 0);
`endif
      tick();
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++)
         run_single($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].zero, vecs[i].ovf);

      // Multiply corners, stall discipline and back-to-back accept
      run_mul("mul_3x0", 32'h3, 32'h0, 1'b0);
      run_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      run_single("b2b_add", 4'd2, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0);

      // Abort in MUL cycle 10: outputs clear at once, no strobe ever follows
      alu_controls = 4'd8;
      operand_a = 32'hFFFFFFFF;
      operand_b = 32'h3;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      repeat (9) tick();
      check("abort_busy_before", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check("abort_result_valid", result_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_result_hi", result_hi, 0);
      check("abort_result", result, 0);
      check("abort_zero", zero, 0);
      model_hi = '0;
      tick();
      rst = 1'b0;
      repeat (40) tick();
      check("abort_idle_busy", busy, 0);
      run_single("post_abort_add", 4'd2, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0);

      // Randomized ops against the model
      for (int n = 0; n < 60; n++) begin
         logic [3:0]   code;
         logic [W-1:0] a;
         logic [W-1:0] b;
         int           sel;
         sel = $urandom_range(0, 9);
         if (sel < 6) code = 4'(ops[sel]);
         else         code = 4'(undef_codes[$urandom_range(0, 9)]);
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 4) == 0) a = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF : 32'h80000000;
         if ($urandom_range(0, 4) == 0) b = ($urandom_range(0, 1) == 1) ? a : 32'h0;
         if (code == 4'd8) run_mul("rnd_mul", a, b, 1'($urandom_range(0, 1)));
         else run_single("rnd", code, a, b, model_res(code, a, b),
                         model_res(code, a, b) == 0, model_ovf(code, a, b));
      end

      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
